// File: rtl/spi_cs_transaction_ctrl.sv
// spi_cs_transaction_ctrl: chip-select framing and byte sequencing above a single-byte SPI master
module spi_cs_transaction_ctrl #(
  parameter int LEN_W        = 4,
  parameter int CS_LEAD_CLKS = 2,
  parameter int CS_LAG_CLKS  = 2,
  parameter int CS_IDLE_CLKS = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_Start,
  input  logic [LEN_W-1:0] i_Len,
  output logic             o_Busy,
  output logic             o_Done,
  input  logic [7:0]       i_TX_Byte,
  input  logic             i_TX_Valid,
  output logic             o_TX_Accept,
  output logic [7:0]       o_RX_Byte,
  output logic             o_RX_DV,
  output logic [7:0]       o_M_TX_Byte,
  output logic             o_M_TX_DV,
  input  logic             i_M_TX_Ready,
  input  logic             i_M_RX_DV,
  input  logic [7:0]       i_M_RX_Byte,
  output logic             o_SPI_CS_n
);
  localparam int MAX_LL = (CS_LEAD_CLKS > CS_LAG_CLKS) ? CS_LEAD_CLKS : CS_LAG_CLKS;
  localparam int MAX_C  = (MAX_LL > CS_IDLE_CLKS) ? MAX_LL : CS_IDLE_CLKS;
  localparam int CW     = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {IDLE, LEAD, LOAD, WAIT_RX, LAG, GAP} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             cs_n_q, cs_n_d, busy_q, busy_d, done_q, done_d;
  logic             tx_acc_q, tx_acc_d, rx_dv_q, rx_dv_d, m_tx_dv_q, m_tx_dv_d;
  logic [7:0]       rx_byte_q, rx_byte_d, m_tx_byte_q, m_tx_byte_d;
  logic             load_go, lead_end, take;

  assign load_go  = i_M_TX_Ready && i_TX_Valid;
  assign lead_end = (state_q == LEAD) && (cnt_q == CW'(CS_LEAD_CLKS - 1));
  // The handshake is already evaluated in the last LEAD cycle so the first
  // master DV lands exactly CS_LEAD_CLKS cycles after CS_n falls.
  assign take     = ((state_q == LOAD) || lead_end) && load_go;

  // Register all state and outputs; reset releases chip select immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_acc_q    <= 1'b0;
      rx_dv_q     <= 1'b0;
      m_tx_dv_q   <= 1'b0;
      rx_byte_q   <= 8'h00;
      m_tx_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tx_acc_q    <= tx_acc_d;
      rx_dv_q     <= rx_dv_d;
      m_tx_dv_q   <= m_tx_dv_d;
      rx_byte_q   <= rx_byte_d;
      m_tx_byte_q <= m_tx_byte_d;
    end
  end

  // Next-state, byte bookkeeping and one-cycle pulse generation.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_acc_d    = take;
    m_tx_dv_d   = take;
    m_tx_byte_d = take ? i_TX_Byte : m_tx_byte_q;
    rx_dv_d     = 1'b0;
    rx_byte_d   = rx_byte_q;
    case (state_q)
      IDLE: begin
        if (i_Start && i_Len != '0) begin
          rem_d   = i_Len;
          state_d = LEAD;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end else if (i_Start) begin
          done_d = 1'b1;
        end
      end
      LEAD:    state_d = lead_end ? (load_go ? WAIT_RX : LOAD) : LEAD;
      LOAD:    state_d = load_go ? WAIT_RX : LOAD;
      WAIT_RX: begin
        if (i_M_RX_DV) begin
          rx_byte_d = i_M_RX_Byte;
          rx_dv_d   = 1'b1;
          rem_d     = (rem_q != '0) ? rem_q - LEN_W'(1) : '0;
          state_d   = (rem_d != '0) ? LOAD : LAG;
        end
      end
      LAG: begin
        if (cnt_q == CW'(CS_LAG_CLKS - 1)) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == CW'(CS_IDLE_CLKS - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q && (state_q == LEAD || state_q == LAG || state_q == GAP)) ? cnt_q + CW'(1) : '0;
  end

  assign o_SPI_CS_n  = cs_n_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_TX_Accept = tx_acc_q;
  assign o_RX_DV     = rx_dv_q;
  assign o_RX_Byte   = rx_byte_q;
  assign o_M_TX_DV   = m_tx_dv_q;
  assign o_M_TX_Byte = m_tx_byte_q;
endmodule
